// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply-divide unit: 32-iteration shift-add multiply and restoring divide,
// with MTHI/MTLO writes and a sign-fixup cycle before the HI/LO update.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MTHi,
  input  logic             MTLo,
  input  logic [WIDTH-1:0] WData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      count;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  // Magnitudes of the live inputs (for loading) and of the latched operands (for iterating).
  logic [WIDTH-1:0] a_in_mag, b_in_mag, mag_a, mag_b;
  assign a_in_mag = (Op[0] && A[WIDTH-1]) ? -A : A;
  assign b_in_mag = (Op[0] && B[WIDTH-1]) ? -B : B;
  assign mag_a    = (op_q[0] && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b    = (op_q[0] && b_q[WIDTH-1]) ? -b_q : b_q;

  // Multiply step: conditionally add the multiplicand into the upper half, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide step: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
  assign div_next  = div_diff[WIDTH+1] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // Sign fixup applied in FIX.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;
  always_comb begin
    prod   = (op_q[0] && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -acc : acc;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (op_q[1]) begin
      if (b_q == '0) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_lo = (op_q[0] && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        res_hi = (op_q[0] && a_q[WIDTH-1]) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = CALC;
      CALC:    if (count == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy      = (state == CALC) || (state == FIX);
    Done      = done_q;
    HiOut     = hi_q;
    LoOut     = lo_q;
    fsm_state = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            op_q  <= Op;
            a_q   <= A;
            b_q   <= B;
            acc   <= Op[1] ? {{WIDTH{1'b0}}, a_in_mag} : {{WIDTH{1'b0}}, b_in_mag};
            count <= '0;
          end else begin
            if (MTHi) hi_q <= WData;
            if (MTLo) lo_q <= WData;
          end
        end
        CALC: begin
          acc   <= op_q[1] ? div_next : mul_next;
          count <= count + 1'b1;
        end
        FIX: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed and randomized checks of hilo_muldiv_unit against an arithmetic reference model.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A, B, WData;
  logic        MTHi, MTLo;
  logic        Busy, Done;
  logic [31:0] HiOut, LoOut;
  logic [1:0]  fsm_state;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .MTHi(MTHi), .MTLo(MTLo), .WData(WData), .Busy(Busy), .Done(Done),
    .HiOut(HiOut), .LoOut(LoOut), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference result {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      2'd0: return {32'b0, a} * {32'b0, b};
      2'd1: return longint'($signed(a)) * longint'($signed(b));
      2'd2: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {sa % sb, sa / sb};
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mt_write(input logic hi_en, input logic lo_en, input logic [31:0] data);
    Start = 1'b0; MTHi = hi_en; MTLo = lo_en; WData = data;
    @(negedge clk);
    MTHi = 1'b0; MTLo = 1'b0;
    if (hi_en) exp_hi = data;
    if (lo_en) exp_lo = data;
    check("mt_hi", HiOut, exp_hi);
    check("mt_lo", LoOut, exp_lo);
  endtask

  // Called at a negedge; starts the op at the next posedge (t0) while hammering the
  // inputs with noise during the run. With chain=1 it returns in the Done cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit chain);
    logic [63:0] r;
    int k, busy_cnt;
    bit hold_ok, seen;
    r = model(op, a, b);
    Start = 1'b1; Op = op; A = a; B = b;
    MTHi = 1'($urandom_range(0, 1)); MTLo = 1'($urandom_range(0, 1)); WData = $urandom;
    k = 0; busy_cnt = 0; hold_ok = 1'b1; seen = 1'b0;
    while (!seen && k < 60) begin
      @(negedge clk);
      k++;
      if (Done) seen = 1'b1;
      else begin
        if (Busy) busy_cnt++;
        if (HiOut !== exp_hi || LoOut !== exp_lo) hold_ok = 1'b0;
        if (k <= 32) begin
          Start = 1'($urandom_range(0, 1)); Op = 2'($urandom_range(0, 3));
          A = $urandom; B = $urandom;
          MTHi = 1'($urandom_range(0, 1)); MTLo = 1'($urandom_range(0, 1)); WData = $urandom;
        end else begin
          Start = 1'b0; MTHi = 1'b0; MTLo = 1'b0;
        end
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    check("done_latency", 64'(k), 64'd34);
    check("busy_cycles", 64'(busy_cnt), 64'd33);
    check("hilo_hold", 64'(hold_ok), 64'd1);
    check("busy_in_done", 64'(Busy), 64'd0);
    check("hi", 64'(HiOut), 64'(r[63:32]));
    check("lo", 64'(LoOut), 64'(r[31:0]));
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    Start = 1'b0; MTHi = 1'b0; MTLo = 1'b0;
    if (!chain) begin
      @(negedge clk);
      check("done_once", 64'(Done), 64'd0);
      check("idle_busy", 64'(Busy), 64'd0);
    end
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
    MTHi = 1'b0; MTLo = 1'b0; WData = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_hi", HiOut, 0);
    check("rst_lo", LoOut, 0);
    check("rst_busy", 64'(Busy), 0);
    check("rst_done", 64'(Done), 0);

    // Reset beats Start and MTHi/MTLo in the same cycle.
    Start = 1'b1; MTHi = 1'b1; MTLo = 1'b1; WData = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rst_prio_busy", 64'(Busy), 0);
    check("rst_prio_hi", HiOut, 0);
    reset = 1'b0; Start = 1'b0; MTHi = 1'b0; MTLo = 1'b0;

    mt_write(1'b1, 1'b0, 32'h1234_5678);
    check("mthi_const", HiOut, 64'h1234_5678);
    mt_write(1'b0, 1'b1, $urandom);
    mt_write(1'b1, 1'b1, $urandom);

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max", {HiOut, LoOut}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_neg", {HiOut, LoOut}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg", {HiOut, LoOut}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd2, 32'd100, 32'd0, 1'b0);
    check("divu_zero", {HiOut, LoOut}, 64'h0000_0064_FFFF_FFFF);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf", {HiOut, LoOut}, 64'h0000_0000_8000_0000);
    run_op(2'd3, 32'hFFFF_FF9C, 32'd0, 1'b0);
    check("div_zero", {HiOut, LoOut}, 64'hFFFF_FF9C_FFFF_FFFF);

    // Back-to-back: second Start lands in the Done cycle.
    run_op(2'd1, $urandom, $urandom, 1'b1);
    run_op(2'd3, $urandom, 32'($urandom_range(1, 1000)), 1'b0);

    // Abort a MULTU with reset at t0+10, then start again immediately.
    Start = 1'b1; Op = 2'd0; A = $urandom; B = $urandom;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_hi", HiOut, 0);
    check("abort_lo", LoOut, 0);
    check("abort_busy", 64'(Busy), 0);
    check("abort_done", 64'(Done), 0);
    exp_hi = '0;
    exp_lo = '0;
    run_op(2'd0, $urandom, $urandom, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, (i != 23) && ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
